// File: rtl/stream_source.sv
// Valid/ready stream transmitter: on start, emits len beats of an incrementing or
// 8-bit LFSR pattern, with optional idle gaps between beats, under full backpressure.
module stream_source #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] seed,
  input  logic              mode,
  input  logic [3:0]        gap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  beat_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  // The LFSR taps are only meaningful for byte-wide data; other widths count up.
  localparam bit LFSR_OK = (DATA_W == 8);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic              mode_q;
  logic [3:0]        gap_q;
  logic [3:0]        gap_cnt;
  logic [DATA_W-1:0] first_value;
  logic              last_beat;

  function automatic logic [DATA_W-1:0] next_value(input logic [DATA_W-1:0] d,
                                                   input logic              lfsr);
    logic [7:0] b;
    b = 8'(d);
    if (lfsr && LFSR_OK)
      return DATA_W'({b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]});
    else
      return d + DATA_W'(1);
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed starts the sequence at 1.
  assign first_value = (mode && LFSR_OK && seed == '0) ? DATA_W'(1) : seed;
  // Only reached in SEND, where len_q is non-zero, so the subtraction cannot wrap.
  assign last_beat   = (beat_count == len_q - LEN_W'(1));

  // NOTE: every piece of state, outputs included, lives in this one clocked block with
  // non-blocking assignments; out_valid is therefore never a combinational function of
  // out_ready, and all registers see consistent pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beat_count <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      gap_q      <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= len;
            mode_q     <= mode;
            gap_q      <= gap;
            beat_count <= '0;
            if (len != '0) begin
              out_data  <= first_value;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= SEND;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        SEND: begin
          // out_valid is always high here, so out_ready alone marks a handshake.
          if (out_ready) begin
            beat_count <= beat_count + LEN_W'(1);
            if (last_beat) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_data <= next_value(out_data, mode_q);
              if (gap_q != '0) begin
                out_valid <= 1'b0;
                gap_cnt   <= gap_q;
                state     <= GAP;
              end
            end
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) begin
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_source.sv
// Directed bench for stream_source: a table of stream vectors with hand-computed beats,
// plus hand-written sequences for backpressure, reset mid-transfer and maximum length.
module tb_stream_source;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic [7:0] seed;
  logic       mode;
  logic [3:0] gap;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic [7:0] beat_count;

  int n_checks = 0;
  int n_errors = 0;

  stream_source #(.DATA_W(8), .LEN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .seed       (seed),
    .mode       (mode),
    .gap        (gap),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [7:0]      len;
    logic [7:0]      seed;
    logic            mode;
    logic [3:0]      gap;
    logic            poke;  // pulse start mid-stream with different parameters
    logic [7:0][7:0] exp;   // exp[k] is beat k
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [7:0] l, input logic [7:0] s,
                              input logic m, input logic [3:0] g, input logic p,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input logic [7:0] e4);
    vec_t v;
    v.name = name; v.len = l; v.seed = s; v.mode = m; v.gap = g; v.poke = p;
    v.exp = '0;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    return v;
  endfunction

  // Starts a stream with out_ready=1 and checks every accepted beat, beat spacing,
  // start latency, done timing, busy and the final beat_count.
  task automatic run_vec(input vec_t v);
    int k    = 0;
    int last = -1;
    int cyc  = 0;
    @(negedge clk);
    start = 1'b1; len = v.len; seed = v.seed; mode = v.mode; gap = v.gap; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.len != 0) begin
      check({v.name, " start valid"}, out_valid, 1);
      check({v.name, " start busy"}, busy, 1);
    end else begin
      check({v.name, " len0 no valid"}, out_valid, 0);
    end
    while (!done && cyc < 200) begin
      if (out_valid) begin
        check($sformatf("%s beat%0d", v.name, k), out_data, (k < 8) ? v.exp[k] : 8'hxx);
        if (k > 0) check($sformatf("%s spacing%0d", v.name, k), cyc - last, v.gap + 1);
        last = cyc;
        k++;
      end
      start = 1'b0;
      if (v.poke && cyc == 1) begin
        start = 1'b1; len = 8'd1; seed = 8'h99; mode = 1'b1; gap = 4'd0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({v.name, " done seen"}, done, 1);
    check({v.name, " beats"}, k, v.len);
    check({v.name, " done latency"}, cyc - last, (v.len == 0) ? 1 : 1);
    check({v.name, " busy low"}, busy, 0);
    check({v.name, " beat_count"}, beat_count, v.len);
    @(negedge clk);
    check({v.name, " done one cycle"}, done, 0);
    check({v.name, " beat_count hold"}, beat_count, v.len);
  endtask

  vec_t vecs [7];

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; seed = '0; mode = 1'b0; gap = '0; out_ready = 1'b0;

    vecs[0] = mk("incr",     8'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 8'hA5, 8'hA6, 8'hA7, 8'h00, 8'h00);
    vecs[1] = mk("gap2",     8'd3, 8'h10, 1'b0, 4'd2, 1'b0, 8'h10, 8'h11, 8'h12, 8'h00, 8'h00);
    vecs[2] = mk("lfsr",     8'd5, 8'h01, 1'b1, 4'd0, 1'b0, 8'h01, 8'h02, 8'h04, 8'h08, 8'h11);
    vecs[3] = mk("lfsr0",    8'd2, 8'h00, 1'b1, 4'd0, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00);
    vecs[4] = mk("wrap",     8'd3, 8'hFE, 1'b0, 4'd0, 1'b0, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00);
    vecs[5] = mk("poke",     8'd4, 8'h20, 1'b0, 4'd1, 1'b1, 8'h20, 8'h21, 8'h22, 8'h23, 8'h00);
    vecs[6] = mk("lfsrgap",  8'd4, 8'h80, 1'b1, 4'd3, 1'b0, 8'h80, 8'h00 /*set below*/, 8'h00, 8'h00, 8'h00);
    // 80 -> {0000000, 1^0^0^0}=01 -> 02 -> 04
    vecs[6].exp[1] = 8'h01; vecs[6].exp[2] = 8'h02; vecs[6].exp[3] = 8'h04;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst beat_count", beat_count, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // len=0: done pulse only
    begin
      vec_t z;
      z = mk("len0", 8'd0, 8'h55, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_vec(z);
    end

    // Backpressure: stalled for 3 edges after start, data and valid must hold
    @(negedge clk);
    start = 1'b1; len = 8'd2; seed = 8'h3C; mode = 1'b0; gap = 4'd0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp stall valid%0d", i), out_valid, 1);
      check($sformatf("bp stall data%0d", i), out_data, 8'h3C);
      check($sformatf("bp stall count%0d", i), beat_count, 0);
      @(negedge clk);
    end
    check("bp held valid", out_valid, 1);
    check("bp held data", out_data, 8'h3C);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp beat1 data", out_data, 8'h3D);
    check("bp beat1 count", beat_count, 1);
    @(negedge clk);
    check("bp done", done, 1);
    check("bp busy", busy, 0);
    check("bp count", beat_count, 2);
    @(negedge clk);
    check("bp done drop", done, 0);

    // Reset after beat 2 of len=5: everything clears, no done pulse, restart works
    start = 1'b1; len = 8'd5; seed = 8'h40; mode = 1'b0; gap = 4'd0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmid count before", beat_count, 2);
    check("rmid data before", out_data, 8'h42);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rmid valid", out_valid, 0);
    check("rmid busy", busy, 0);
    check("rmid count", beat_count, 0);
    check("rmid data", out_data, 0);
    begin
      int saw_done = 0;
      for (int i = 0; i < 8; i++) begin
        if (done || out_valid) saw_done++;
        @(negedge clk);
      end
      check("rmid quiet", saw_done, 0);
    end
    run_vec(vecs[0]);

    // Maximum length: 255 beats, incrementing from 0, beat_count must reach 255 unwrapped
    @(negedge clk);
    start = 1'b1; len = 8'hFF; seed = 8'h00; mode = 1'b0; gap = 4'd0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int k = 0;
      int bad = 0;
      int cyc = 0;
      while (!done && cyc < 400) begin
        if (out_valid) begin
          if (out_data !== 8'(k)) bad++;
          k++;
        end
        @(negedge clk);
        cyc++;
      end
      check("max done", done, 1);
      check("max beats", k, 255);
      check("max data errors", bad, 0);
      check("max count", beat_count, 8'hFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_source.md
# stream_source

Parameterised valid/ready stream transmitter that drives the input side of the single-stage pipeline register, and any other sink on the same handshake. On a start pulse it emits a programmed number of beats, either an incrementing or an LFSR byte pattern, with optional idle gaps. It honours backpressure under strict valid/ready rules. It serves as the on-chip traffic producer for pipeline bring-up and for the bench that checks the register under load.

## Interface
- DATA_W, 8, data width; LFSR mode is defined only for DATA_W=8 (for other widths, mode=1 behaves as mode=0)
- LEN_W, 8, width of len and beat_count
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- len  in  LEN_W  beats to send; latched at start
- seed  in  DATA_W  first beat value; latched at start
- mode  in  1  0 = increment, 1 = LFSR; latched at start
- gap  in  4  idle cycles inserted after each accepted beat except the last; latched at start
- out_valid  out  1  beat valid
- out_ready  in  1  sink ready
- out_data  out  DATA_W  beat payload
- busy  out  1  high in SEND and GAP
- done  out  1  one-cycle completion pulse
- beat_count  out  LEN_W  beats accepted since the last start

## Operation
- States: IDLE, SEND, GAP, DONE.
- Handshake: a beat transfers on a rising edge where out_valid and out_ready are both 1.
- IDLE:
  - start=1 with len≠0: latch inputs, clear beat_count, go to SEND with out_data=seed.
  - start=1 with len=0: go to DONE, no beats.
  - start=0: stay in IDLE.
- SEND:
  - out_valid=1.
  - On handshake, beat_count increments.
  - If that beat was beat number len, go to DONE.
  - Else if gap≠0, go to GAP with the gap counter loaded with gap.
  - Else stay in SEND with the next value.
- GAP:
  - out_valid=0; the gap counter decrements each cycle.
  - When the counter is 1, go to SEND with the next value presented.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Next value (computed on handshake):
  - mode=0: out_data+1, wrapping modulo 2^DATA_W.
  - mode=1: {d[6:0], d[7]^d[5]^d[4]^d[3]}.
  - mode=1 with seed=0: the first beat is 8'h01 (the LFSR never locks up).
- start outside IDLE is ignored. len/seed/mode/gap changes mid-transfer have no effect.
- out_ready is ignored when out_valid=0.
- out_valid never depends combinationally on out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, busy=0, done=0, beat_count=0, state=IDLE.
- Start latency: start sampled high at edge N gives out_valid=1 and busy=1 after edge N.
- Completion: the last handshake at edge M gives done=1 and busy=0 after edge M; done=0 after M+1.
  - With len=0, done is high for the cycle after the start edge.
- Throughput: 1 beat/cycle with gap=0 and out_ready=1. With gap=g, one beat per g+1 cycles at best.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid hold stable and the state does not change.
- Only registered values drive out_valid, out_data, busy, done and beat_count.
- Reset asserted mid-transfer:
  - After that edge, all outputs take their reset values.
  - The partially sent stream is abandoned with no done pulse.
- beat_count holds its final value in IDLE until the next accepted start.
- len=2^LEN_W-1 is supported; beat_count must not wrap before done.

## Test plan
- Basic increment:
  - Stimulus: seed=A5, len=3, mode=0, gap=0, out_ready=1.
  - Required: out_data A5, A6, A7 on three consecutive cycles; done pulse one cycle after the A7 handshake; beat_count=3; busy low afterwards.
- Backpressure:
  - Stimulus: seed=3C, len=2, out_ready=0 for 3 cycles after start, then 1.
  - Required: out_valid=1 and out_data=3C stable across the stall; then 3C, 3D accepted; done; beat_count=2.
- Gaps:
  - Stimulus: gap=2, len=3, seed=10, out_ready=1.
  - Required: out_valid pattern 1,0,0,1,0,0,1 carrying 10, 11, 12; no gap after the last beat.
- LFSR and wrap:
  - Stimulus A: mode=1, seed=01, len=5. Required: 01, 02, 04, 08, 11.
  - Stimulus B: mode=1, seed=00. Required: first beat 01.
  - Stimulus C: mode=0, seed=FE, len=3. Required: FE, FF, 00.
- Corner cases:
  - len=0: done pulse with no out_valid.
  - start pulsed during SEND: ignored; the stream and beat_count are unaffected.
- Reset mid-transfer:
  - Stimulus: rst_n=0 for one edge after beat 2 of len=5.
  - Required: out_valid=0, busy=0, beat_count=0 next cycle; no done pulse; a new start runs normally.
